// File: rtl/vector_component_serializer.sv
// Buffers packed 3-component signed vectors and emits them as x, y, z.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   in_valid/ready  - input handshake; in_vector packs {x, y, z}
//   out_valid/ready - output handshake
//   out_comp        - current component
//   out_idx         - 0=x, 1=y, 2=z
//   out_last        - set on the z component
//   vec_count       - vectors fully emitted (wraps)
//   fifo_level      - vectors queued in the FIFO
module vector_component_serializer #(
  parameter int COMP_W     = 19,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  localparam int VEC_W     = 3 * COMP_W,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int LVL_W     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  in_vector,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COMP_W-1:0] out_comp,
  output logic [1:0]        out_idx,
  output logic              out_last,
  output logic [CNT_W-1:0]  vec_count,
  output logic [LVL_W-1:0]  fifo_level
);

  typedef enum logic [1:0] {
    IDLE,
    EMIT_X,
    EMIT_Y,
    EMIT_Z
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [VEC_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [VEC_W-1:0] hold_q;
  logic [VEC_W-1:0] vec_d;

  logic              push;
  logic              pop;
  logic              have;
  logic              valid_d;
  logic [COMP_W-1:0] comp_d;
  logic [1:0]        idx_d;
  logic              last_d;

  assign in_ready = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  // Only the registered level counts, so a same-cycle push is seen next cycle.
  assign have     = (fifo_level != '0);

  // State register plus registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      out_valid <= 1'b0;
      out_comp  <= '0;
      out_idx   <= 2'd0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= vec_d;
      out_valid <= valid_d;
      out_comp  <= comp_d;
      out_idx   <= idx_d;
      out_last  <= last_d;
    end
  end

  // Next-state logic; the pop from EMIT_Z keeps vectors back to back.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (have) begin
          pop     = 1'b1;
          state_d = EMIT_X;
        end
      end
      EMIT_X: begin
        if (out_ready) state_d = EMIT_Y;
      end
      EMIT_Y: begin
        if (out_ready) state_d = EMIT_Z;
      end
      EMIT_Z: begin
        if (out_ready) begin
          if (have) begin
            pop     = 1'b1;
            state_d = EMIT_X;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming state; stalls leave them unchanged.
  always_comb begin
    vec_d   = pop ? mem[rd_ptr] : hold_q;
    valid_d = 1'b0;
    comp_d  = '0;
    idx_d   = 2'd0;
    last_d  = 1'b0;
    case (state_d)
      EMIT_X: begin
        valid_d = 1'b1;
        comp_d  = vec_d[VEC_W-1 -: COMP_W];
      end
      EMIT_Y: begin
        valid_d = 1'b1;
        comp_d  = vec_d[2*COMP_W-1 -: COMP_W];
        idx_d   = 2'd1;
      end
      EMIT_Z: begin
        valid_d = 1'b1;
        comp_d  = vec_d[COMP_W-1:0];
        idx_d   = 2'd2;
        last_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_vector;
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_count <= '0;
    end else if (state_q == EMIT_Z && out_ready) begin
      vec_count <= vec_count + CNT_W'(1);
    end
  end

endmodule
